regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the single-write, two-read datapath register file.
- Adds:
  - configurable width, depth and read/write port counts;
  - same-cycle write-to-read bypass;
  - optional hard-wired zero register;
  - synchronous clear;
  - per-register busy scoreboard for load-use hazard detection.
- Sits in the decode stage, between the instruction decoder and the ALU operand muxes.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high; clears all registers, busy bits and wr_conflict.
- rd_addr, in, NUM_RD*ADDR_W, packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rd_data, out, NUM_RD*DATA_W, packed read data, combinational.
- rd_busy, out, NUM_RD, per-port: addressed register has a pending producer.
- wr_en, in, NUM_WR, per-port write enable.
- wr_addr, in, NUM_WR*ADDR_W, packed write addresses.
- wr_data, in, NUM_WR*DATA_W, packed write data.
- iss_en, in, 1, instruction issued with a deferred destination; marks iss_addr busy.
- iss_addr, in, ADDR_W, destination being reserved.
- wr_conflict, out, 1, registered pulse: two or more write ports hit the same address last cycle.

Behaviour:
- Reset (sync, active-high; overrides all same-cycle writes and issues):
  - all registers become 0;
  - all busy bits become 0;
  - wr_conflict becomes 0.
- rd_data and rd_busy are combinational, so they reflect state immediately after reset.
- Write:
  - at the rising edge, each port with wr_en=1 writes wr_data into wr_addr.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Write collision:
  - two or more enabled ports with the same address: highest-index port wins.
  - wr_conflict=1 for exactly the following cycle; otherwise 0.
  - A discarded write to reg 0 never counts as a collision.
- Read, 0-cycle latency:
  - rd_data[i] = registers[rd_addr[i]].
  - Bypass: if any enabled write port in the same cycle targets rd_addr[i], rd_data[i] = that port's wr_data, using the highest-index matching port.
  - ZERO_REG=1 and rd_addr[i]=0: rd_data[i]=0, with no bypass.
- Scoreboard (one busy bit per register):
  - Set: iss_en=1 sets busy[iss_addr] at the edge.
  - Clear: any enabled write to an address clears its busy bit at the edge.
  - Simultaneous set and clear of the same address: set wins, because the new producer supersedes the completing one.
  - ZERO_REG=1: busy[0] is constant 0 and iss_addr=0 is ignored.
- rd_busy[i] = busy[rd_addr[i]] AND NOT (same-cycle enabled write hitting rd_addr[i]), because the bypass supplies the data.
- Re-issue to an already-busy register leaves it busy; no error.
- No combinational path from iss_* to rd_*; issue is visible only from the next cycle.
- Arithmetic/width: no arithmetic; all packed vectors are little-endian by port index.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W/ADDR_W defaults;
  - ZERO_ADDR constant;
  - helper function for packed-slice extraction.
- One sub-module, regfile_scoreboard:
  - owns the busy-bit vector, set/clear priority and the rd_busy lookup.
- Storage, write priority, bypass mux and conflict detect stay in regfile_mp.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert reset with wr_en=1 to r5 in the same cycle -> next cycle rd_data(r5)=0 and busy all 0.
- Bypass: wr_en[0]=1, wr_addr=7, wr_data=0x12345678, rd_addr[1]=7 in the same cycle -> rd_data[1]=0x12345678 combinationally; next cycle it reads from storage with the same value.
- Collision: ports 0 and 1 both write r3 with 0xAAAA and 0x5555 -> r3=0x5555, wr_conflict=1 for exactly one cycle, then 0.
- Zero register: write 0xFFFFFFFF to r0 and iss_en to r0 -> rd_data(r0)=0, rd_busy=0, wr_conflict=0 even if both ports target r0.
- Scoreboard: iss_en to r9 -> next cycle rd_busy=1; write r9=0x42 -> rd_busy=0 in the write cycle (bypass gives 0x42) and thereafter.
- Set/clear race: iss_en to r4 and wr_en to r4 in the same cycle -> after the edge r4 holds the new data and busy[4]=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-datapath definitions: default widths, the zero-register address and
// a helper for locating port slices inside packed multi-port vectors.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_ADDR  = 0;

    // Low bit of slice idx in a packed vector of w-bit fields.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for load-use hazard detection; a new issue outranks a
// completing write to the same register.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_live,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [ADDR_W-1:0] ra [NUM_RD];

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wa
        assign wa[p] = wr_addr[slice_lo(p, ADDR_W) +: ADDR_W];
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_ra
        assign ra[i] = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
    end

    always_comb begin
        busy_d = busy_q;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_live[p]) busy_d[wa[p]] = 1'b0;
        end
        if (iss_en) busy_d[iss_addr] = 1'b1;
        if (ZERO_REG) busy_d[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    // A same-cycle write satisfies the consumer through the bypass.
    always_comb begin
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_busy[i] = busy_q[ra[i]];
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_live[p] && wa[p] == ra[i]) rd_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, optional zero register,
// write-collision flag and a busy scoreboard for the decode stage.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     wr_conflict
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    logic [ADDR_W-1:0] ra [NUM_RD];
    logic [NUM_WR-1:0] wr_live;
    logic              conflict_d;
    logic              conflict_q;

    // Writes to the zero register are dropped here, so they neither store,
    // bypass, clear busy nor count as collisions.
    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        assign wa[p]      = wr_addr[slice_lo(p, ADDR_W) +: ADDR_W];
        assign wd[p]      = wr_data[slice_lo(p, DATA_W) +: DATA_W];
        assign wr_live[p] = wr_en[p] && !(ZERO_REG && wa[p] == ADDR_W'(ZERO_ADDR));
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign ra[i] = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
    end

    // Ascending port order makes the highest-index port win a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) regs_q[r] <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_live[p]) regs_q[wa[p]] <= wd[p];
            end
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            for (int unsigned q = p + 1; q < NUM_WR; q++) begin
                if (wr_live[p] && wr_live[q] && wa[p] == wa[q]) conflict_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) conflict_q <= 1'b0;
        else       conflict_q <= conflict_d;
    end

    assign wr_conflict = conflict_q;

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_data[slice_lo(i, DATA_W) +: DATA_W] = regs_q[ra[i]];
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_live[p] && wa[p] == ra[i]) begin
                    rd_data[slice_lo(i, DATA_W) +: DATA_W] = wd[p];
                end
            end
            if (ZERO_REG && ra[i] == ADDR_W'(ZERO_ADDR)) begin
                rd_data[slice_lo(i, DATA_W) +: DATA_W] = '0;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_live  (wr_live),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios then random traffic,
// checked against an array-based reference model.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              wr_conflict;

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .NUM_WR   (NW),
        .ZERO_REG (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .wr_conflict (wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    busy;
        logic             conflict;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: architectural register contents, busy flags, pending flag.
    logic [DW-1:0] m_mem [32];
    bit            m_busy [32];
    bit            m_conf;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        for (int p = 0; p < NW; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] == a) v = wr_data[p*DW +: DW];
        return v;
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        for (int p = 0; p < NW; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_edge();
        bit nc;
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
            m_conf = 1'b0;
        end else begin
            nc = 1'b0;
            for (int p = 0; p < NW; p++)
                for (int q = p + 1; q < NW; q++)
                    if (wr_en[p] && wr_en[q] && wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW]
                        && wr_addr[p*AW +: AW] != 0) nc = 1'b1;
            for (int p = 0; p < NW; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] != 0) begin
                    m_mem[wr_addr[p*AW +: AW]]  = wr_data[p*DW +: DW];
                    m_busy[wr_addr[p*AW +: AW]] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
            m_conf = nc;
        end
    endtask

    task automatic step(input logic rst, input logic [NW-1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic ie, input logic [AW-1:0] ia,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        exp_t e;
        reset    = rst;
        wr_en    = we;
        wr_addr  = {a1, a0};
        wr_data  = {d1, d0};
        iss_en   = ie;
        iss_addr = ia;
        rd_addr  = {r1, r0};
        for (int i = 0; i < NR; i++) begin
            e.data[i*DW +: DW] = model_read(rd_addr[i*AW +: AW]);
            e.busy[i]          = model_busy(rd_addr[i*AW +: AW]);
        end
        e.conflict = m_conf;
        sb_q.push_back(e);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle once stimulus has been issued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int i = 0; i < NR; i++) begin
                    check($sformatf("rd_data%0d", i), 64'(rd_data[i*DW +: DW]),
                          64'(e.data[i*DW +: DW]));
                    check($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(e.busy[i]));
                end
                check("wr_conflict", 64'(wr_conflict), 64'(e.conflict));
            end
        end
    end

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
        m_conf   = 1'b0;
        reset    = 1'b1;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        rd_addr  = '0;
        @(posedge clk);
        #1;

        // Reset overrides a same-cycle write.
        step(0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0, 5, 5);
        step(0, 2'b00, 0, 0, 0, 0, 1, 5, 5, 5);
        step(1, 2'b01, 5, 0, 32'h11111111, 0, 1, 5, 5, 5);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
        // Bypass then storage read.
        step(0, 2'b01, 7, 0, 32'h12345678, 0, 0, 0, 0, 7);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7);
        // Collision: port 1 wins, flag for exactly one cycle.
        step(0, 2'b11, 3, 3, 32'hAAAA, 32'h5555, 0, 0, 3, 3);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
        // Zero register ignores writes, issues and collisions.
        step(0, 2'b11, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // Scoreboard set, bypass clear.
        step(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 9);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
        step(0, 2'b01, 9, 0, 32'h42, 0, 0, 0, 9, 9);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
        // Issue and write to the same register: data lands, busy stays set.
        step(0, 2'b10, 0, 4, 0, 32'hCAFE, 1, 4, 4, 4);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4);
        // Re-issue to a busy register.
        step(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4);

        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
                 rand_addr(), rand_addr(), $urandom, $urandom,
                 1'($urandom_range(0, 1)), rand_addr(), rand_addr(), rand_addr());
        end

        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
